flappy_referee: RTL and testbench



---
 rtl/flappy_pkg.sv | 20 ++
 rtl/bcd_counter3.sv | 41 ++++
 rtl/flappy_referee.sv | 164 ++++++++++++++++
 tb/tb_flappy_referee.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// flappy_pkg: types and constants shared by the flappy referee blocks.
//   game_state_t - game-level FSM states
//   bcd3_t       - three packed BCD digits, [11:8] hundreds
//   bcd_gt()     - magnitude compare of two bcd3_t values, hundreds first
package flappy_pkg;

    typedef enum logic [1:0] {IDLE, PLAYING, DYING, GAME_OVER} game_state_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic [11:0] bcd3_t;

    function automatic logic bcd_gt(input bcd3_t a, input bcd3_t b);
        if (a[11:8] != b[11:8]) return a[11:8] > b[11:8];
        if (a[7:4]  != b[7:4])  return a[7:4]  > b[7:4];
        return a[3:0] > b[3:0];
    endfunction

endpackage

// File: rtl/bcd_counter3.sv
// bcd_counter3: three-digit BCD up-counter that sticks at 999.
//   clk   - clock
//   reset - synchronous active-high reset to 000
//   clr   - synchronous clear to 000, wins over inc
//   inc   - add one (ignored once the count is 999)
//   q     - current count, [11:8] hundreds
module bcd_counter3
    import flappy_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clr,
    input  logic  inc,
    output bcd3_t q
);

    bcd3_t r_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_q <= '0;
        end else if (inc && (r_q != 12'h999)) begin
            // ripple carry digit by digit; the 999 guard above means the
            // hundreds digit never has to roll over
            if (r_q[3:0] != 4'd9) begin
                r_q[3:0] <= r_q[3:0] + 4'd1;
            end else begin
                r_q[3:0] <= 4'd0;
                if (r_q[7:4] != 4'd9) begin
                    r_q[7:4] <= r_q[7:4] + 4'd1;
                end else begin
                    r_q[7:4]  <= 4'd0;
                    r_q[11:8] <= r_q[11:8] + 4'd1;
                end
            end
        end
    end

    assign q = r_q;

endmodule

// File: rtl/flappy_referee.sv
// flappy_referee: game referee between the pipe generator and bird physics.
// Detects bird/pipe and bird/screen-edge collisions, scores passed pipes in
// BCD, keeps the best score and runs the game-level FSM.
//   clk, reset          - clock, synchronous active-high reset
//   start               - user start; only a rising edge acts
//   pipe_x              - pipe column left edge
//   pipe_y0 / pipe_y1   - lower pipe top edge / upper pipe bottom edge
//   bird_y              - bird top row
//   run                 - high in PLAYING (enables pipes and bird)
//   game_over           - high in DYING and GAME_OVER
//   hit                 - one-cycle pulse when a collision ends play
//   score / best        - 3-digit BCD current and best score
module flappy_referee
    import flappy_pkg::*;
#(
    parameter int N            = 11,
    parameter int BIRD_X       = 160,
    parameter int BIRD_SIZE    = 15,
    parameter int PIPE_WIDTH   = 1,
    parameter int SCREEN_H     = flappy_pkg::SCREEN_H,
    parameter int DEATH_CYCLES = 12500000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] pipe_x,
    input  logic [N-1:0] pipe_y0,
    input  logic [N-1:0] pipe_y1,
    input  logic [N-1:0] bird_y,
    output logic         run,
    output logic         game_over,
    output logic         hit,
    output logic [11:0]  score,
    output logic [11:0]  best
);

    // counter only ever holds DEATH_CYCLES-1 down to 0
    localparam int CW = (DEATH_CYCLES > 1) ? $clog2(DEATH_CYCLES) : 1;
    localparam logic [CW-1:0] DEATH_LOAD = CW'(DEATH_CYCLES - 1);

    // geometry is done one bit wider than the buses so sums cannot wrap
    localparam logic [N:0] BIRD_L = (N+1)'(BIRD_X);
    localparam logic [N:0] BIRD_R = (N+1)'(BIRD_X + BIRD_SIZE - 1);
    localparam logic [N:0] FLOOR  = (N+1)'(SCREEN_H - 1);

    game_state_t r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_passed, w_passed_nxt;
    bcd3_t         r_best, w_best_nxt;
    logic          r_hit, w_hit_nxt;
    logic          r_start_q;

    logic          w_clr, w_inc, w_run, w_game_over;
    bcd3_t         w_score;

    logic [N:0] w_px, w_px_r, w_by, w_by_b, w_y0, w_y1;
    logic       w_start_rise, w_x_overlap, w_pipe_hit, w_edge_hit;
    logic       w_collide, w_pass_evt, w_pass_clr;

    assign w_px   = {1'b0, pipe_x};
    assign w_px_r = w_px + (N+1)'(PIPE_WIDTH - 1);
    assign w_by   = {1'b0, bird_y};
    assign w_by_b = w_by + (N+1)'(BIRD_SIZE - 1);
    assign w_y0   = {1'b0, pipe_y0};
    assign w_y1   = {1'b0, pipe_y1};

    assign w_start_rise = start & ~r_start_q;

    assign w_x_overlap = (w_px <= BIRD_R) && (w_px_r >= BIRD_L);
    assign w_pipe_hit  = w_x_overlap && ((w_by <= w_y1) || (w_by_b >= w_y0));
    assign w_edge_hit  = (w_by == '0) || (w_by_b >= FLOOR);
    assign w_collide   = w_pipe_hit || w_edge_hit;

    // a pipe scores once when its right edge clears the bird; it re-arms
    // only after the generator respawns it to the right of the bird
    assign w_pass_evt = !r_passed && (w_px_r < BIRD_L);
    assign w_pass_clr = (w_px > BIRD_R);

    bcd_counter3 u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .inc   (w_inc),
        .q     (w_score)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_passed  <= 1'b0;
            r_best    <= '0;
            r_hit     <= 1'b0;
            r_start_q <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_passed  <= w_passed_nxt;
            r_best    <= w_best_nxt;
            r_hit     <= w_hit_nxt;
            r_start_q <= start;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_passed_nxt = r_passed;
        w_best_nxt   = r_best;
        w_hit_nxt    = 1'b0;
        w_clr        = 1'b0;
        w_inc        = 1'b0;
        w_run        = 1'b0;
        w_game_over  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_rise) begin
                    w_clr        = 1'b1;
                    w_passed_nxt = 1'b0;
                    w_state_nxt  = PLAYING;
                end
            end
            PLAYING: begin
                w_run = 1'b1;
                // collision takes priority over a same-cycle pass
                if (w_collide) begin
                    w_state_nxt = DYING;
                    w_hit_nxt   = 1'b1;
                    w_cnt_nxt   = DEATH_LOAD;
                end else if (w_pass_evt) begin
                    w_inc        = 1'b1;
                    w_passed_nxt = 1'b1;
                end else if (w_pass_clr) begin
                    w_passed_nxt = 1'b0;
                end
            end
            DYING: begin
                w_game_over = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = GAME_OVER;
                    if (bcd_gt(w_score, r_best)) w_best_nxt = w_score;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            GAME_OVER: begin
                w_game_over = 1'b1;
                if (w_start_rise) begin
                    w_clr        = 1'b1;
                    w_passed_nxt = 1'b0;
                    w_state_nxt  = PLAYING;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign run       = w_run;
    assign game_over = w_game_over;
    assign hit       = r_hit;
    assign score     = w_score;
    assign best      = r_best;

endmodule

// File: tb/tb_flappy_referee.sv
module tb_flappy_referee;

    localparam int N      = 11;
    localparam int BX     = 160;
    localparam int BS     = 15;
    localparam int PW     = 1;
    localparam int SH     = 480;
    localparam int DC     = 5;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [N-1:0]  pipe_x, pipe_y0, pipe_y1, bird_y;
    logic          run, game_over, hit;
    logic [11:0]   score, best;

    int n_cmp = 0;
    int n_err = 0;

    flappy_referee #(
        .N(N), .BIRD_X(BX), .BIRD_SIZE(BS), .PIPE_WIDTH(PW),
        .SCREEN_H(SH), .DEATH_CYCLES(DC)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .pipe_x(pipe_x), .pipe_y0(pipe_y0), .pipe_y1(pipe_y1), .bird_y(bird_y),
        .run(run), .game_over(game_over), .hit(hit), .score(score), .best(best)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 playing, 2 dying, 3 over; scores kept as plain integers
    int m_phase, m_score, m_best, m_left;
    bit m_passed, m_hit, m_sq, m_valid = 1'b0;

    function automatic logic [11:0] to_bcd(input int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    always @(posedge clk) begin
        bit rise, col, pev, clr_p;
        int px, pxr, by, byb;
        px  = int'(pipe_x);
        pxr = px + PW - 1;
        by  = int'(bird_y);
        byb = by + BS - 1;
        rise  = start && !m_sq;
        col   = ((px <= BX + BS - 1) && (pxr >= BX) &&
                 (by <= int'(pipe_y1) || byb >= int'(pipe_y0))) ||
                (by == 0) || (byb >= SH - 1);
        pev   = !m_passed && (pxr < BX);
        clr_p = px > BX + BS - 1;
        m_sq  <= reset ? 1'b0 : start;
        m_hit <= 1'b0;
        if (reset) begin
            m_phase <= 0; m_score <= 0; m_best <= 0; m_passed <= 1'b0; m_left <= 0;
            m_valid <= 1'b1;
        end else begin
            case (m_phase)
                0, 3: if (rise) begin
                    m_phase <= 1; m_score <= 0; m_passed <= 1'b0;
                end
                1: if (col) begin
                    m_phase <= 2; m_hit <= 1'b1; m_left <= DC;
                end else if (pev) begin
                    m_score <= (m_score < 999) ? m_score + 1 : 999;
                    m_passed <= 1'b1;
                end else if (clr_p) begin
                    m_passed <= 1'b0;
                end
                default: if (m_left <= 1) begin
                    m_phase <= 3;
                    if (m_score > m_best) m_best <= m_score;
                end else begin
                    m_left <= m_left - 1;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            n_cmp += 5;
            if (run !== (m_phase == 1)) begin
                n_err++; $display("FAIL cyc_run got=%0b want=%0b t=%0t", run, (m_phase == 1), $time);
            end
            if (game_over !== (m_phase >= 2)) begin
                n_err++; $display("FAIL cyc_game_over got=%0b want=%0b t=%0t", game_over, (m_phase >= 2), $time);
            end
            if (hit !== m_hit) begin
                n_err++; $display("FAIL cyc_hit got=%0b want=%0b t=%0t", hit, m_hit, $time);
            end
            if (score !== to_bcd(m_score)) begin
                n_err++; $display("FAIL cyc_score got=%h want=%h t=%0t", score, to_bcd(m_score), $time);
            end
            if (best !== to_bcd(m_best)) begin
                n_err++; $display("FAIL cyc_best got=%h want=%h t=%0t", best, to_bcd(m_best), $time);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic press();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic pass_once();
        pipe_x = 11'd640; tick(1);
        pipe_x = 11'd159; tick(1);
    endtask

    task automatic die_edge();
        pipe_x = 11'd640; bird_y = 11'd0; tick(1);
        chk("die_hit", {11'd0, hit}, 12'h001);
        bird_y = 11'd210; tick(DC + 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0;
        pipe_x = 11'd640; pipe_y1 = 11'd200; pipe_y0 = 11'd230; bird_y = 11'd210;
        tick(2);
        chk("rst_run",   {11'd0, run}, 12'h000);
        chk("rst_go",    {11'd0, game_over}, 12'h000);
        chk("rst_hit",   {11'd0, hit}, 12'h000);
        chk("rst_score", score, 12'h000);
        chk("rst_best",  best, 12'h000);
        reset = 1'b0; tick(1);

        // start held three cycles: one transition only
        start = 1'b1; tick(1);
        chk("start_run", {11'd0, run}, 12'h001);
        tick(2); start = 1'b0; tick(1);
        chk("start_run_hold", {11'd0, run}, 12'h001);
        chk("start_score", score, 12'h000);

        // bird in the gap while overlapping the pipe, then into upper pipe
        pipe_x = 11'd165; tick(10);
        chk("gap_run", {11'd0, run}, 12'h001);
        chk("gap_hit", {11'd0, hit}, 12'h000);
        bird_y = 11'd195; tick(1);
        chk("pipe_hit", {11'd0, hit}, 12'h001);
        chk("pipe_go",  {11'd0, game_over}, 12'h001);
        chk("pipe_run", {11'd0, run}, 12'h000);
        tick(1);
        chk("hit_pulse_end", {11'd0, hit}, 12'h000);
        start = 1'b1; tick(1); start = 1'b0;      // ignored in DYING
        chk("dying_ignores_start", {11'd0, run}, 12'h000);
        bird_y = 11'd210; tick(DC + 1);
        chk("over_best0", best, 12'h000);

        // pass detection
        press();
        pipe_x = 11'd161; tick(1);
        pipe_x = 11'd160; tick(1);
        chk("pre_pass_score", score, 12'h000);
        pipe_x = 11'd159; tick(1);
        chk("pass1_score", score, 12'h001);
        chk("model_pass1", to_bcd(m_score), 12'h001);
        tick(20);
        chk("pass_hold_score", score, 12'h001);
        pass_once();
        chk("pass2_score", score, 12'h002);

        // floor hit: 465+14 = 479
        pipe_x = 11'd640; bird_y = 11'd465; tick(1);
        chk("floor_hit", {11'd0, hit}, 12'h001);
        bird_y = 11'd210; tick(DC + 1);
        chk("best2", best, 12'h002);

        // simultaneous pass and collision at score 5
        press();
        repeat (5) pass_once();
        chk("score5", score, 12'h005);
        pipe_x = 11'd640; tick(1);
        pipe_x = 11'd159; bird_y = 11'd0; tick(1);
        chk("simul_hit",   {11'd0, hit}, 12'h001);
        chk("simul_score", score, 12'h005);
        bird_y = 11'd210; tick(DC + 1);
        chk("best5", best, 12'h005);

        // best 7, restart from GAME_OVER, reset mid-death
        press();
        repeat (7) pass_once();
        die_edge();
        chk("best7", best, 12'h007);
        press();
        chk("restart_run",   {11'd0, run}, 12'h001);
        chk("restart_score", score, 12'h000);
        chk("restart_best",  best, 12'h007);
        pipe_x = 11'd640; bird_y = 11'd0; tick(1);
        bird_y = 11'd210; tick(1);                  // counter now 3
        reset = 1'b1; tick(1);
        chk("rst_dying_go",   {11'd0, game_over}, 12'h000);
        chk("rst_dying_run",  {11'd0, run}, 12'h000);
        chk("rst_dying_best", best, 12'h000);
        reset = 1'b0; tick(1);

        // saturation at 999
        press();
        repeat (999) pass_once();
        chk("sat999", score, 12'h999);
        pass_once();
        chk("sat_hold", score, 12'h999);
        die_edge();
        chk("best999", best, 12'h999);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
